// File: rtl/pit_timer.sv
// Programmable interval timer: prescaler and divider built from loadable down-counter bit cells.
// tint is registered, one clk wide; there is no backpressure and writes always win over counting.

module pit_cell (
   input  logic clk,
   input  logic resl,
   input  logic ld,
   input  logic d,
   input  logic en,
   input  logic ci,
   output logic q,
   output logic co
);

   // A down-count flips a bit when every lower bit is zero; the borrow continues past a zero bit.
   assign co = ci & ~q;

   always_ff @(posedge clk or negedge resl) begin
      if (!resl)
         q <= 1'b0;
      else if (ld)
         q <= d;
      else if (en && ci)
         q <= ~q;
   end

endmodule

module pit_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resl,
   input  logic             pre_wr,
   input  logic             div_wr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] pre_q,
   output logic [WIDTH-1:0] div_q,
   output logic             run,
   output logic             tint
);

   logic [WIDTH-1:0] pre_reg;
   logic [WIDTH-1:0] div_reg;
   logic [WIDTH-1:0] div_reg_nxt;
   logic [WIDTH:0]   pre_b;
   logic [WIDTH:0]   div_b;
   logic             pborrow;
   logic             dborrow;
   logic             pre_ld;
   logic             div_en;
   logic             div_ld;
   logic [WIDTH-1:0] pre_d;
   logic [WIDTH-1:0] div_d;

   assign pre_b[0] = 1'b1;
   assign div_b[0] = 1'b1;
   assign pborrow  = pre_b[WIDTH];
   assign dborrow  = div_b[WIDTH];

   // A borrow out of the top bit means the count sits at zero: reload replaces the wrap.
   assign pre_ld = pre_wr | (run & pborrow);
   assign pre_d  = pre_wr ? wdata : pre_reg;
   assign div_en = run & pborrow & ~pre_wr;
   assign div_ld = div_wr | (div_en & dborrow);
   assign div_d  = div_wr ? wdata : div_reg;

   assign div_reg_nxt = div_wr ? wdata : div_reg;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cells
      pit_cell u_pre (
         .clk  (clk),
         .resl (resl),
         .ld   (pre_ld),
         .d    (pre_d[i]),
         .en   (run),
         .ci   (pre_b[i]),
         .q    (pre_q[i]),
         .co   (pre_b[i+1])
      );
      pit_cell u_div (
         .clk  (clk),
         .resl (resl),
         .ld   (div_ld),
         .d    (div_d[i]),
         .en   (div_en),
         .ci   (div_b[i]),
         .q    (div_q[i]),
         .co   (div_b[i+1])
      );
   end

   always_ff @(posedge clk or negedge resl) begin
      if (!resl) begin
         pre_reg <= '0;
         div_reg <= '0;
         run     <= 1'b0;
         tint    <= 1'b0;
      end else begin
         if (pre_wr)
            pre_reg <= wdata;
         div_reg <= div_reg_nxt;
         run     <= (div_reg_nxt != '0);
         // Any strobe on this edge suppresses the request, even one to the other register.
         tint    <= div_en & dborrow & ~div_wr;
      end
   end

endmodule

// File: tb/tb_pit_timer.sv
// Directed bench for pit_timer: reset, period, minimum period, stop, write collision, wide wrap.

module tb_pit_timer;

   localparam int WIDTH = 16;

   logic             clk;
   logic             resl;
   logic             pre_wr;
   logic             div_wr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] pre_q;
   logic [WIDTH-1:0] div_q;
   logic             run;
   logic             tint;

   int n_chk;
   int n_pass;

   pit_timer #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .resl   (resl),
      .pre_wr (pre_wr),
      .div_wr (div_wr),
      .wdata  (wdata),
      .pre_q  (pre_q),
      .div_q  (div_q),
      .run    (run),
      .tint   (tint)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_pre(input logic [WIDTH-1:0] v);
      pre_wr = 1'b1;
      wdata  = v;
      tick();
      pre_wr = 1'b0;
   endtask

   task automatic wr_div(input logic [WIDTH-1:0] v);
      div_wr = 1'b1;
      wdata  = v;
      tick();
      div_wr = 1'b0;
   endtask

   task automatic do_reset();
      resl = 1'b0;
      #3;
      resl = 1'b1;
      tick();
   endtask

   initial begin
      int hi;
      n_chk  = 0;
      n_pass = 0;
      resl   = 1'b0;
      pre_wr = 1'b0;
      div_wr = 1'b0;
      wdata  = '0;
      tick();
      tick();
      chk("rst_pre_q", 32'(pre_q), 32'd0);
      chk("rst_div_q", 32'(div_q), 32'd0);
      chk("rst_run",   32'(run),   32'd0);
      chk("rst_tint",  32'(tint),  32'd0);
      resl = 1'b1;
      tick();

      // Reset mid-count clears asynchronously and leaves the timer idle.
      wr_pre(16'd5);
      wr_div(16'd5);
      for (int i = 0; i < 7; i++) tick();
      chk("mid_pre_nz", 32'(pre_q != 0 || div_q != 0), 32'd1);
      resl = 1'b0;
      #2;
      chk("arst_pre_q", 32'(pre_q), 32'd0);
      chk("arst_div_q", 32'(div_q), 32'd0);
      chk("arst_run",   32'(run),   32'd0);
      chk("arst_tint",  32'(tint),  32'd0);
      resl = 1'b1;
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (tint) hi++;
      end
      chk("idle_tint_cnt", 32'(hi), 32'd0);
      chk("idle_run",      32'(run), 32'd0);

      // Basic period: pre=1, div=2 gives a pulse every 6 clocks.
      wr_pre(16'd1);
      chk("pre_only_run", 32'(run), 32'd0);
      wr_div(16'd2);
      chk("basic_run",   32'(run),   32'd1);
      chk("basic_div_0", 32'(div_q), 32'd2);
      hi = 0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         chk($sformatf("basic_tint_%0d", k), 32'(tint), 32'((k % 6) == 0));
         chk($sformatf("basic_div_%0d", k), 32'(div_q), 32'(2 - ((k / 2) % 3)));
         if (tint) hi++;
      end
      chk("basic_pulses", 32'(hi), 32'd4);

      // Minimum period: pre=0, div=1 alternates.
      do_reset();
      wr_pre(16'd0);
      wr_div(16'd1);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("min_tint_%0d", k), 32'(tint), 32'((k % 2) == 0));
      end

      // Stop: div=0 written while counting freezes the counters.
      do_reset();
      wr_pre(16'd3);
      wr_div(16'd4);
      for (int i = 0; i < 5; i++) tick();
      chk("stop_pre_before", 32'(pre_q), 32'd2);
      chk("stop_div_before", 32'(div_q), 32'd3);
      wr_div(16'd0);
      chk("stop_run", 32'(run), 32'd0);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tint) hi++;
      end
      chk("stop_pre_frozen", 32'(pre_q), 32'd1);
      chk("stop_div_frozen", 32'(div_q), 32'd0);
      chk("stop_tint_cnt",   32'(hi),    32'd0);

      // Collision: prescaler write on the terminal-count edge wins.
      do_reset();
      wr_pre(16'd1);
      wr_div(16'd1);
      for (int i = 0; i < 3; i++) tick();
      chk("col_pre_zero", 32'(pre_q), 32'd0);
      chk("col_div_zero", 32'(div_q), 32'd0);
      wr_pre(16'd7);
      chk("col_pre_q", 32'(pre_q), 32'd7);
      chk("col_div_q", 32'(div_q), 32'd0);
      chk("col_tint",  32'(tint),  32'd0);
      hi = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (tint) hi++;
      end
      chk("col_quiet", 32'(hi), 32'd0);
      tick();
      chk("col_tint_8",  32'(tint),  32'd1);
      chk("col_div_rl",  32'(div_q), 32'd1);
      chk("col_pre_rl",  32'(pre_q), 32'd7);
      tick();
      chk("col_tint_w1", 32'(tint),  32'd0);

      // Wide values: prescaler wraps 0 -> 0xFFFF by reload while divider steps once.
      do_reset();
      wr_div(16'd1);
      wr_pre(16'hFFFF);
      chk("wide_pre_ld", 32'(pre_q), 32'h0000FFFF);
      chk("wide_div_ld", 32'(div_q), 32'd1);
      for (int i = 0; i < 3; i++) tick();
      chk("wide_pre_dec", 32'(pre_q), 32'h0000FFFC);
      hi = 0;
      for (int i = 3; i < 65535; i++) begin
         tick();
         if (tint) hi++;
      end
      chk("wide_pre_zero", 32'(pre_q), 32'd0);
      chk("wide_div_hold", 32'(div_q), 32'd1);
      tick();
      if (tint) hi++;
      chk("wide_pre_rl",   32'(pre_q), 32'h0000FFFF);
      chk("wide_div_step", 32'(div_q), 32'd0);
      chk("wide_tint_cnt", 32'(hi),    32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
